// File: rtl/verdict_collector.sv
// Verdict collector: timestamps active monitor cycles, buffers them as records and streams each
// record as a header word plus one word per active output. Optional macro: VERDICT_COLLECTOR_DROP_CNT_EN.
module verdict_collector #(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 64,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic signed [NUM_OUT*DATA_W-1:0]  out_data,
  input  logic        [NUM_OUT-1:0]         out_aktv,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic        [DATA_W-1:0]          m_data,
  output logic                              m_last,
  output logic                              overflow,
  output logic        [15:0]                drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int REC_W = TS_W + NUM_OUT + NUM_OUT*DATA_W;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  function automatic logic [CW-1:0] first_set(input logic [NUM_OUT-1:0] mask, input int from);
    first_set = '0;
    for (int i = NUM_OUT-1; i >= 0; i--)
      if (i >= from && mask[i]) first_set = CW'(i);
  endfunction

  function automatic logic has_above(input logic [NUM_OUT-1:0] mask, input logic [CW-1:0] cur);
    has_above = 1'b0;
    for (int i = 0; i < NUM_OUT; i++)
      if (i > int'(cur) && mask[i]) has_above = 1'b1;
  endfunction

  state_t                  state, state_nxt;
  logic [TS_W-1:0]         ts_q;
  logic [AW:0]             count;
  logic [AW-1:0]           wptr, rptr;
  logic [REC_W-1:0]        mem [DEPTH];
  logic [CW-1:0]           cursor;
  logic [TS_W-1:0]         sh_ts_p1;
  logic [NUM_OUT-1:0]      sh_mask_p1;
  logic [NUM_OUT*DATA_W-1:0] sh_data_p1;
  logic                    cap_vld_p0, full, wr, drop, pop, hs;

  assign cap_vld_p0 = en && (|out_aktv);
  // Fullness looks only at the registered count, so a same-edge pop never rescues a record.
  assign full = (count == (AW+1)'(DEPTH));
  assign wr   = cap_vld_p0 && !full;
  assign drop = cap_vld_p0 && full;
  assign pop  = (state == IDLE) && (count != '0);
  assign hs   = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q     <= '0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      cursor   <= '0;
    end else begin
      if (en) ts_q <= ts_q + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      if (wr)   wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (hs && state == HDR)  cursor <= first_set(sh_mask_p1, 0);
      if (hs && state == DATA) cursor <= first_set(sh_mask_p1, int'(cursor) + 1);
    end
  end

  // Stage p0: record storage; stage p1: shadow of the record being streamed.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {ts_q, out_aktv, out_data};
    if (pop) {sh_ts_p1, sh_mask_p1, sh_data_p1} <= mem[rptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (count != '0) state_nxt = HDR;
      HDR:  if (m_ready) state_nxt = DATA;
      DATA: if (m_ready && !has_above(sh_mask_p1, cursor)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    case (state)
      HDR: begin
        m_valid = 1'b1;
        m_data  = DATA_W'({sh_mask_p1, sh_ts_p1});
      end
      DATA: begin
        m_valid = 1'b1;
        m_data  = sh_data_p1[int'(cursor)*DATA_W +: DATA_W];
        m_last  = !has_above(sh_mask_p1, cursor);
      end
      default: ;
    endcase
  end

`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      drop_q <= '0;
    else if (drop) drop_q <= sat_inc16(drop_q);
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_verdict_collector.sv
// Directed bench for verdict_collector: table of single records plus hand sequences for corner cases.
module tb_verdict_collector;

  typedef struct {
    logic [3:0]       aktv;
    logic [3:0][63:0] v;
    int               n;
    logic [3:0][63:0] w;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic signed [255:0] out_data = '0;
  logic [3:0]         out_aktv = '0;
  logic               m_ready = 1'b0;
  logic               m_valid, m_last, overflow;
  logic [63:0]        m_data;
  logic [15:0]        drop_cnt;
  logic               v8, l8, o8, r8;
  logic [63:0]        d8;
  logic [15:0]        dc8;

  int errors = 0;
  int checks = 0;
  logic [31:0] tsm;
  logic [63:0] ew [5];
  logic [63:0] q8 [$];
  bit mon8_on = 1'b1;
  vec_t tbl [4];

  always #5 clk = ~clk;

  verdict_collector dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  verdict_collector #(.TS_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_valid(v8), .m_ready(r8), .m_data(d8), .m_last(l8),
    .overflow(o8), .drop_cnt(dc8)
  );

  assign r8 = 1'b1;

  // Reference timestamp: counts edges with en=1 since reset.
  always @(posedge clk or negedge rst)
    if (!rst) tsm <= '0;
    else if (en) tsm <= tsm + 1;

  always @(negedge clk)
    if (mon8_on && v8 && r8) q8.push_back(d8);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cap(input logic [3:0] aktv, input logic [3:0][63:0] v, output logic [31:0] ts);
    out_aktv = aktv;
    out_data = v;
    ts = tsm;
    step();
    out_aktv = '0;
  endtask

  task automatic collect(input int n, input logic [63:0] w [5], input string nm, input bit bp);
    int got, cyc;
    logic [63:0] pd;
    logic pv, pr;
    got = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    while (got < n && cyc < 100) begin
      m_ready = bp ? ((cyc % 3) == 0) : 1'b1;
      if (pv && !pr) begin
        chk({nm, "_stall_valid"}, 64'(m_valid), 64'd1);
        chk({nm, "_stall_data"}, m_data, pd);
      end
      if (m_valid && m_ready) begin
        chk($sformatf("%s_word%0d", nm, got), m_data, w[got]);
        chk($sformatf("%s_last%0d", nm, got), 64'(m_last), 64'(got == n-1));
        got++;
      end
      pd = m_data; pv = m_valid; pr = m_ready;
      step();
      cyc++;
    end
    m_ready = 1'b0;
    if (got < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d words required %0d", nm, got, n);
    end
  endtask

  initial begin
    logic [31:0] ts, ts0, held;
    logic [3:0][63:0] vv;
    int guard;
    bit found;
    logic [15:0] exp_drop;

    tbl[0].aktv = 4'b1000; tbl[0].v = {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd123};
    tbl[0].n = 1; tbl[0].w = {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[1].aktv = 4'b0110; tbl[1].v = {64'd77, 64'd22, 64'd11, 64'd66};
    tbl[1].n = 2; tbl[1].w = {64'd0, 64'd0, 64'd22, 64'd11};
    tbl[2].aktv = 4'b0001; tbl[2].v = {64'd1, 64'd2, 64'd3, 64'h8000_0000_0000_0000};
    tbl[2].n = 1; tbl[2].w = {64'd0, 64'd0, 64'd0, 64'h8000_0000_0000_0000};
    tbl[3].aktv = 4'b1001; tbl[3].v = {64'd9, 64'd44, 64'd33, 64'd5};
    tbl[3].n = 2; tbl[3].w = {64'd0, 64'd0, 64'd9, 64'd5};

    // Reset state
    #12;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b1;
    step();

    // Timestamp wrap on the TS_W=8 instance, same captures seen at ts 255/256 by the 32-bit one
    en = 1'b1;
    guard = 0;
    while (tsm != 32'd255 && guard < 400) begin step(); guard++; end
    vv = {64'd0, 64'd0, 64'd0, 64'd77};
    cap(4'b0001, vv, ts);
    vv = {64'd0, 64'd0, 64'd0, 64'd88};
    cap(4'b0001, vv, ts);
    ew[0] = 64'h0000_0001_0000_00FF; ew[1] = 64'd77;
    collect(2, ew, "wrap32_a", 1'b0);
    ew[0] = 64'h0000_0001_0000_0100; ew[1] = 64'd88;
    collect(2, ew, "wrap32_b", 1'b0);
    repeat (3) step();
    mon8_on = 1'b0;
    chk("wrap8_count", 64'(q8.size()), 64'd4);
    chk("wrap8_hdr255", (q8.size() > 0) ? q8[0] : 64'hDEAD, 64'h1FF);
    chk("wrap8_val0", (q8.size() > 1) ? q8[1] : 64'hDEAD, 64'd77);
    chk("wrap8_hdr0", (q8.size() > 2) ? q8[2] : 64'hDEAD, 64'h100);
    chk("wrap8_val1", (q8.size() > 3) ? q8[3] : 64'hDEAD, 64'd88);

    // Single record at ts=500
    guard = 0;
    while (tsm != 32'd500 && guard < 600) begin step(); guard++; end
    vv = {64'd0, 64'd7, 64'd0, 64'd3};
    cap(4'b0101, vv, ts);
    ew[0] = 64'h0000_0005_0000_01F4; ew[1] = 64'd3; ew[2] = 64'd7;
    collect(3, ew, "single", 1'b0);

    // Table of records
    for (int i = 0; i < 4; i++) begin
      cap(tbl[i].aktv, tbl[i].v, ts);
      ew[0] = {28'd0, tbl[i].aktv, ts};
      for (int k = 0; k < tbl[i].n; k++) ew[k+1] = tbl[i].w[k];
      collect(tbl[i].n + 1, ew, $sformatf("tbl%0d", i), 1'b0);
    end

    // All active with backpressure
    vv = {64'd4, 64'd3, 64'd2, 64'd1};
    cap(4'b1111, vv, ts);
    ew[0] = {28'd0, 4'b1111, ts}; ew[1] = 64'd1; ew[2] = 64'd2; ew[3] = 64'd3; ew[4] = 64'd4;
    collect(5, ew, "bp", 1'b1);
    chk("pre_ovf_overflow", 64'(overflow), 64'd0);

    // en gating: activity with en=0 is ignored and the timestamp freezes
    step();
    held = tsm;
    en = 1'b0;
    out_aktv = 4'b0010;
    out_data = {64'd0, 64'd0, 64'd42, 64'd0};
    for (int c = 0; c < 20; c++) begin
      step();
      if (c % 5 == 4) chk($sformatf("engate_valid%0d", c), 64'(m_valid), 64'd0);
    end
    en = 1'b1;
    vv = {64'd0, 64'd0, 64'd42, 64'd0};
    cap(4'b0010, vv, ts);
    ew[0] = {28'd0, 4'b0010, held}; ew[1] = 64'd42;
    collect(2, ew, "engate", 1'b0);

    // Overflow: 10 captures against a stalled consumer, 9 survive
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vv = {64'd0, 64'd0, 64'd0, 64'(i)};
      cap(4'b0001, vv, ts);
      if (i == 0) ts0 = ts;
    end
    step(); step();
    chk("ovf_overflow", 64'(overflow), 64'd1);
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    for (int k = 0; k < 9; k++) begin
      ew[0] = {28'd0, 4'b0001, ts0 + 32'(k)}; ew[1] = 64'(k);
      collect(2, ew, $sformatf("ovf_rec%0d", k), 1'b0);
    end
    repeat (3) step();
    chk("ovf_empty_after", 64'(m_valid), 64'd0);

    // Reset during the second data word of a 4-word record, with another record queued
    m_ready = 1'b1;
    vv = {64'd0, 64'd30, 64'd20, 64'd10};
    cap(4'b0111, vv, ts);
    vv = {64'd0, 64'd0, 64'd0, 64'd99};
    cap(4'b0001, vv, ts);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (m_valid && m_data == 64'd20) begin
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(m_valid), 64'd0);
        chk("midrst_data", m_data, 64'd0);
        found = 1'b1;
      end else begin
        step();
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL midrst_reach: got no second data word required word 20");
    end
    step();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("postrst_valid%0d", c), 64'(m_valid), 64'd0);
    end
    chk("postrst_overflow", 64'(overflow), 64'd0);
    chk("postrst_drop", 64'(drop_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/verdict_collector.md
Name: verdict_collector

Overview:
- Sits directly downstream of the compiled monitor topEntity.
- Samples the monitor's per-stream outputs and their aktv flags every cycle, and timestamps each cycle that has at least one active output.
- Buffers these cycles as records in a FIFO, then serialises each record as a valid/ready word stream for host readout or log dumping.
- Decouples monitor verdict bursts from a slower consumer and reports records that had to be dropped.

Parameters:
- NUM_OUT, 4, number of monitor output streams
- DATA_W, 64, width of each output value and of stream words
- TS_W, 32, timestamp counter width; TS_W+NUM_OUT <= DATA_W
- DEPTH, 8, FIFO depth in records; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  capture/timestamp enable; same signal as the monitor's en
- out_data  in  NUM_OUT*DATA_W  monitor outputs, stream i at bits [i*DATA_W +: DATA_W], signed
- out_aktv  in  NUM_OUT  monitor output_i_aktv flags
- m_valid  out  1  stream word valid
- m_ready  in  1  consumer ready
- m_data  out  DATA_W  stream word
- m_last  out  1  final word of the current record
- overflow  out  1  sticky: at least one record dropped since reset
- drop_cnt  out  16  dropped-record count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): timestamp=0, FIFO empty, state IDLE, m_valid=0, m_data=0, m_last=0, overflow=0, drop_cnt=0.
- Timestamp counter: increments by 1 on each clk edge with en=1, wraps modulo 2^TS_W, holds while en=0.
- Capture: at an edge with en=1 and out_aktv!=0, form record {ts, mask=out_aktv, all out_data}.
  - ts is the counter value before that edge's increment.
  - If FIFO count<DEPTH, write the record; otherwise drop it, set overflow, and increment drop_cnt.
  - "Full" uses the registered count only. A record is dropped at count==DEPTH even if a load happens on the same edge.
- en=0: no capture; the drain side keeps running.
- Drain FSM: IDLE, HDR, DATA.
  - IDLE: if the FIFO is non-empty, pop the head into a shadow register at the next edge and go to HDR. The shadow is extra storage, so total capacity is DEPTH+1 records.
  - HDR: m_valid=1; m_data = {zero pad, mask at [TS_W +: NUM_OUT], ts at [0 +: TS_W]}; m_last=1 only if mask has exactly one bit... no: header never carries m_last. On a handshake, go to DATA with the cursor at the lowest set mask bit.
  - DATA: m_data = value of stream at cursor; m_last=1 when no higher set bit remains. On a handshake, advance the cursor to the next higher set bit. After the last word, go to IDLE.
  - Each record is therefore 1 + popcount(mask) words, in ascending stream index order.
  - One idle cycle between records is acceptable. Back-to-back IDLE→HDR is allowed when the FIFO is non-empty.
- Handshake: a transfer occurs when m_valid & m_ready at a clk edge. While m_valid=1 and m_ready=0, m_data and m_last hold stable. m_data=0 and m_last=0 whenever m_valid=0.
- Latency: a record captured at edge E0 is loaded at E1; its header is valid from after E1.
- Simultaneous capture and pop: both happen; count is unchanged.
- drop_cnt saturates at 16'hFFFF.
- Reset mid-record: the stream aborts immediately (m_valid=0) and all buffered records are lost.

Optional Feature:
- Macro: VERDICT_COLLECTOR_DROP_CNT_EN.
- Defined: a 16-bit saturating drop counter drives drop_cnt as described.
- Undefined: no counter register; drop_cnt tied to 0. overflow still behaves as specified.

Test Plan:
- Single record: after reset, hold en=1; at ts=500 drive out_aktv=4'b0101, out_data={0,7,0,3} (stream3..0) for one cycle. → Header data=32'd500 | (5<<32), then 3, then 7 with m_last=1. m_ready=1 throughout.
- All-active plus backpressure: aktv=4'b1111, values 1,2,3,4; toggle m_ready 1,0,0,1,... → 5 words (header, 1, 2, 3, 4) with no duplication or loss. m_data is stable during stalls.
- Overflow: m_ready=0; capture 10 consecutive records with aktv=4'b0001 (DEPTH=8). → 9 records retained (8 FIFO + shadow), overflow=1, drop_cnt=1. Then release m_ready → 9 records drain, ts values consecutive.
- en gating: en=0 for 20 cycles with aktv=4'b0010 asserted → no records, timestamp frozen. Raise en → next record's ts equals the value held before en fell.
- Reset mid-record: assert rst=0 during the second DATA word of a 4-word record → m_valid drops asynchronously. After release, no residual words and overflow=0.
- Timestamp wrap (TS_W=8 build): capture at counter 255 and then the next cycle → headers carry ts 255 then 0.
